// File: rtl/mt_reg_file.sv
// Multithreaded integer register file: one write port, two registered read ports,
// one bank per hardware thread, cleared by a sequential sweep after reset.
module mt_reg_file #(
  parameter int unsigned XLEN     = 64,
  parameter int unsigned NTHREADS = 4,
  parameter int unsigned NREGS    = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          init_busy,
  input  logic                          wr_en,
  input  logic [$clog2(NTHREADS)-1:0]   wr_tid,
  input  logic [$clog2(NREGS)-1:0]      wr_addr,
  input  logic [XLEN-1:0]               wr_data,
  input  logic                          rd_en,
  input  logic [$clog2(NTHREADS)-1:0]   rd_tid,
  input  logic [$clog2(NREGS)-1:0]      rs1_addr,
  input  logic [$clog2(NREGS)-1:0]      rs2_addr,
  output logic [XLEN-1:0]               rs1_data,
  output logic [XLEN-1:0]               rs2_data
);

  localparam int unsigned TW    = $clog2(NTHREADS);
  localparam int unsigned RW    = $clog2(NREGS);
  localparam int unsigned PW    = TW + RW;
  localparam int unsigned DEPTH = NTHREADS * NREGS;

  localparam logic [0:0] CLEAR = 1'b0;
  localparam logic [0:0] READY = 1'b1;

  logic [0:0]      state, state_nxt;
  logic [PW-1:0]   ptr, ptr_nxt;
  logic            mem_we;
  logic [PW-1:0]   mem_waddr;
  logic [XLEN-1:0] mem_wdata;
  logic [XLEN-1:0] rd1_c, rd2_c;

  logic [XLEN-1:0] mem [DEPTH];

  // State and clear pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR;
      ptr       <= '0;
      init_busy <= 1'b1;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      init_busy <= (state_nxt == CLEAR);
    end
  end

  // Next state and the single array write port (sweep or writeback)
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    mem_we    = 1'b0;
    mem_waddr = ptr;
    mem_wdata = '0;
    case (state)
      CLEAR: begin
        mem_we  = 1'b1;
        ptr_nxt = ptr + PW'(1);
        if (ptr == PW'(DEPTH - 1)) state_nxt = READY;
      end
      READY: begin
        if (wr_en && (wr_addr != '0)) begin
          mem_we    = 1'b1;
          mem_waddr = {wr_tid, wr_addr};
          mem_wdata = wr_data;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  // Storage carries no reset so it maps onto block RAM
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= mem_wdata;
  end

  // Read resolution: hardwired zero, then same-cycle write bypass, then array
  always_comb begin
    rd1_c = mem[{rd_tid, rs1_addr}];
    if (rs1_addr == '0)
      rd1_c = '0;
    else if (wr_en && (wr_tid == rd_tid) && (wr_addr == rs1_addr))
      rd1_c = wr_data;
  end

  always_comb begin
    rd2_c = mem[{rd_tid, rs2_addr}];
    if (rs2_addr == '0)
      rd2_c = '0;
    else if (wr_en && (wr_tid == rd_tid) && (wr_addr == rs2_addr))
      rd2_c = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rs1_data <= '0;
      rs2_data <= '0;
    end else if ((state == READY) && rd_en) begin
      rs1_data <= rd1_c;
      rs2_data <= rd2_c;
    end
  end

endmodule

// File: tb/tb_mt_reg_file.sv
// Self-checking bench for mt_reg_file: directed scenarios plus random traffic
// compared every cycle against an array-based reference model.
module tb_mt_reg_file;

  localparam int unsigned XL    = 64;
  localparam int unsigned NT    = 4;
  localparam int unsigned NR    = 32;
  localparam int unsigned DEPTH = NT * NR;

  logic          clk = 1'b0;
  logic          rst;
  logic          init_busy;
  logic          wr_en;
  logic [1:0]    wr_tid;
  logic [4:0]    wr_addr;
  logic [XL-1:0] wr_data;
  logic          rd_en;
  logic [1:0]    rd_tid;
  logic [4:0]    rs1_addr;
  logic [4:0]    rs2_addr;
  logic [XL-1:0] rs1_data;
  logic [XL-1:0] rs2_data;

  mt_reg_file #(.XLEN(XL), .NTHREADS(NT), .NREGS(NR)) dut (
    .clk      (clk),
    .rst      (rst),
    .init_busy(init_busy),
    .wr_en    (wr_en),
    .wr_tid   (wr_tid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .rd_tid   (rd_tid),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data)
  );

  always #5 clk = ~clk;

  int unsigned assertions = 0;
  int unsigned failures   = 0;

  // Reference model: architectural contents per thread, cycles left in the clear
  logic [XL-1:0] model [NT][NR];
  int            clear_left;
  logic [XL-1:0] exp1, exp2;

  task automatic check(input string tag, input logic [XL-1:0] got, input logic [XL-1:0] exp);
    assertions++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [XL-1:0] resolve(input logic [4:0] a);
    if (a == 0) return '0;
    if (wr_en && wr_tid == rd_tid && wr_addr == a) return wr_data;
    return model[rd_tid][a];
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int t = 0; t < NT; t++)
        for (int r = 0; r < NR; r++) model[t][r] = '0;
      clear_left = DEPTH;
      exp1 = '0;
      exp2 = '0;
    end else if (clear_left > 0) begin
      clear_left--;
    end else begin
      if (rd_en) begin
        exp1 = resolve(rs1_addr);
        exp2 = resolve(rs2_addr);
      end
      if (wr_en && wr_addr != 0) model[wr_tid][wr_addr] = wr_data;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("busy", XL'(init_busy), XL'(clear_left > 0));
    check("rs1", rs1_data, exp1);
    check("rs2", rs2_data, exp2);
  endtask

  task automatic idle();
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic write(input logic [1:0] t, input logic [4:0] a, input logic [XL-1:0] d);
    wr_en = 1'b1; wr_tid = t; wr_addr = a; wr_data = d;
  endtask

  task automatic read(input logic [1:0] t, input logic [4:0] a1, input logic [4:0] a2);
    rd_en = 1'b1; rd_tid = t; rs1_addr = a1; rs2_addr = a2;
  endtask

  // Runs until init_busy drops, returning the number of edges taken
  task automatic wait_sweep(output int n);
    n = 0;
    while (init_busy && n < 1000) begin
      cycle();
      n++;
    end
  endtask

  task automatic read_all_zero(input string tag);
    for (int t = 0; t < NT; t++)
      for (int a = 0; a < NR; a++) begin
        idle();
        read(2'(t), 5'(a), 5'(NR - 1 - a));
        cycle();
        check(tag, rs1_data, '0);
        check(tag, rs2_data, '0);
      end
    idle();
  endtask

  initial begin
    int n;
    idle();
    wr_tid = '0; wr_addr = '0; wr_data = '0;
    rd_tid = '0; rs1_addr = '0; rs2_addr = '0;
    clear_left = DEPTH;
    exp1 = '0; exp2 = '0;

    // Reset sweep
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cycle();
    check("rst_rs1", rs1_data, '0);
    check("rst_busy", XL'(init_busy), XL'(1));
    rst = 1'b0;
    wait_sweep(n);
    check("sweep_len", XL'(n), XL'(DEPTH));
    read_all_zero("sweep_zero");

    // Basic write then read; other thread unaffected
    write(2, 5, 64'hDEADBEEF_CAFEF00D);
    cycle();
    idle();
    read(2, 5, 5);
    cycle();
    check("basic_rs1", rs1_data, 64'hDEADBEEF_CAFEF00D);
    check("basic_rs2", rs2_data, 64'hDEADBEEF_CAFEF00D);
    read(1, 5, 5);
    cycle();
    check("iso_rs1", rs1_data, '0);

    // Register 0 is hardwired to zero
    idle();
    write(0, 0, '1);
    cycle();
    idle();
    for (int t = 0; t < NT; t++) begin
      read(2'(t), 0, 0);
      cycle();
      check("zero_rs1", rs1_data, '0);
      check("zero_rs2", rs2_data, '0);
    end

    // Write-first bypass only within the same thread
    idle();
    write(3, 7, 64'h11);
    cycle();
    write(3, 7, 64'h22);
    read(3, 7, 7);
    cycle();
    check("byp_rs1", rs1_data, 64'h22);
    check("byp_rs2", rs2_data, 64'h22);
    idle();
    write(3, 7, 64'h11);
    cycle();
    write(1, 7, 64'h22);
    read(3, 7, 7);
    cycle();
    check("nobyp_rs1", rs1_data, 64'h11);
    check("nobyp_rs2", rs2_data, 64'h11);

    // Outputs hold while rd_en is low
    idle();
    write(0, 4, 64'hAB);
    cycle();
    idle();
    read(0, 4, 4);
    cycle();
    for (int i = 0; i < 5; i++) begin
      rd_en = 1'b0;
      rd_tid = 2'($urandom);
      rs1_addr = 5'($urandom);
      rs2_addr = 5'($urandom);
      cycle();
      check("hold_rs1", rs1_data, 64'hAB);
      check("hold_rs2", rs2_data, 64'hAB);
    end

    // Writes during the sweep are dropped
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    write(0, 1, 64'h55);
    wait_sweep(n);
    check("sweep2_len", XL'(n), XL'(DEPTH));
    idle();
    read(0, 1, 1);
    cycle();
    check("clrwr_rs1", rs1_data, '0);

    // Reset mid-sweep restarts it and loses earlier contents
    idle();
    write(2, 9, 64'h1234);
    cycle();
    idle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (60) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    wait_sweep(n);
    check("midrst_len", XL'(n), XL'(DEPTH));
    read_all_zero("midrst_zero");

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 999) == 0);
      wr_en    = 1'($urandom);
      wr_tid   = 2'($urandom);
      wr_addr  = 5'($urandom);
      wr_data  = {$urandom, $urandom};
      rd_en    = ($urandom_range(0, 3) != 0);
      rd_tid   = 2'($urandom);
      rs1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom);
      rs2_addr = 5'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
